// File: rtl/imm_ext_pkg.sv
// Shared op encodings and helpers for the immediate-extension stage.
package imm_ext_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ZERO = 3'd0;
  localparam logic [OP_W-1:0] OP_SIGN = 3'd1;
  localparam logic [OP_W-1:0] OP_LUI  = 3'd2;
  localparam logic [OP_W-1:0] OP_BOFF = 3'd3;
  localparam logic [OP_W-1:0] OP_JTGT = 3'd4;

  // Codes above OP_JTGT are reserved and treated as illegal.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op <= OP_JTGT);
  endfunction
endpackage

// File: rtl/imm_ext_pipe_if.sv
// Push/pop handshake bundle of the immediate-extension queue.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
// the sender holds its payload stable while valid is 1 and ready is 0.
interface imm_ext_pipe_if
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int JIDX_W = 26,
  parameter int TAG_W  = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [OP_W-1:0]          in_op;
  logic [IMM_W-1:0]         in_imm;
  logic [JIDX_W-1:0]        in_jidx;
  logic [DATA_W-JIDX_W-3:0] in_pc_hi;
  logic [TAG_W-1:0]         in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [TAG_W-1:0]         out_tag;

  modport master (
    output in_valid, in_op, in_imm, in_jidx, in_pc_hi, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_imm, in_jidx, in_pc_hi, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational extender: turns an op plus raw immediate/jump fields into a DATA_W operand.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int JIDX_W = 26
) (
  input  logic [OP_W-1:0]          op,
  input  logic [IMM_W-1:0]         imm,
  input  logic [JIDX_W-1:0]        jidx,
  input  logic [DATA_W-JIDX_W-3:0] pc_hi,
  output logic [DATA_W-1:0]        data,
  output logic                     bad_op
);
  logic [DATA_W-1:0]  sext;
  logic [2*IMM_W-1:0] lui_w;

  assign sext  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign lui_w = {imm, {IMM_W{1'b0}}};

  always_comb begin
    data   = '0;
    bad_op = !is_legal_op(op);
    case (op)
      OP_ZERO: data = {{(DATA_W-IMM_W){1'b0}}, imm};
      OP_SIGN: data = sext;
      OP_LUI:  data = DATA_W'(lui_w);
      OP_BOFF: data = {sext[DATA_W-3:0], 2'b00};
      OP_JTGT: data = {pc_hi, jidx, 2'b00};
      default: data = '0;
    endcase
  end
endmodule

// File: rtl/imm_ext_pipe.sv
// Buffered immediate-generation stage: extends at push, queues result+tag in a DEPTH-entry FIFO.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int JIDX_W = 26,
  parameter int TAG_W  = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  imm_ext_pipe_if.slave              bus,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       err_clr,
  output logic                       illegal
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] ext_data;
  logic              bad_op;
  logic              push;
  logic              pop;

  imm_ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .JIDX_W (JIDX_W)
  ) u_core (
    .op     (bus.in_op),
    .imm    (bus.in_imm),
    .jidx   (bus.in_jidx),
    .pc_hi  (bus.in_pc_hi),
    .data   (ext_data),
    .bad_op (bad_op)
  );

  // in_ready ignores out_ready so a full queue never pushes, even while popping.
  assign bus.in_ready  = (count < CNT_W'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = data_mem[rd_ptr];
  assign bus.out_tag   = tag_mem[rd_ptr];
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      illegal <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        tag_mem[i]  <= '0;
      end
    end else begin
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          data_mem[wr_ptr] <= ext_data;
          tag_mem[wr_ptr]  <= bus.in_tag;
          wr_ptr           <= next_ptr(wr_ptr);
        end
        if (pop) rd_ptr <= next_ptr(rd_ptr);
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
      // A flushed push never happened, so it cannot flag an illegal op.
      if (push && bad_op && !flush) illegal <= 1'b1;
      else if (err_clr)             illegal <= 1'b0;
    end
  end
endmodule
